// File: rtl/keystroke_pkg.sv
// Shared opcodes, keystroke bit positions and FSM state encoding for the
// keystroke front-end.
package keystroke_pkg;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_MODE  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam int KS_W      = 12;
  localparam int KS_COMMIT = 8;
  localparam int KS_MODE   = 9;
  localparam int KS_CLEAR  = 10;
  localparam int KS_PAUSE  = 11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_CLEARING
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
  } cmd_t;

endpackage

// File: rtl/key_debounce.sv
// One keystroke bit: 2-flop synchroniser followed by a stability counter.
// The debounced bit flips after DEB_CYCLES consecutive differing samples.
module key_debounce #(
  parameter int DEB_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);

  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // cnt counts 0..DEB_CYCLES-1; the DEB_CYCLES-th differing sample flips deb.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      deb   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keystroke_sequencer.sv
// Keystroke front-end: debounces the raw vector, turns button/switch events
// into queued commands and issues them to the core under run/pause control.
module keystroke_sequencer
  import keystroke_pkg::*;
#(
  parameter int DEB_CYCLES = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_raw,
  input  logic          rst,
  input  logic [11:0]   keystroke,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [1:0]    cmd_op,
  output logic [7:0]    cmd_data,
  output logic          mode,
  output logic          paused,
  output logic          overflow,
  output logic [CW-1:0] fifo_count
);

  logic [KS_W-1:0] deb;
  logic            commit_q, mode_q, clear_q;
  logic            commit_rise, clear_rise, mode_chg, pause_lvl;

  for (genvar g = 0; g < KS_W; g++) begin : g_deb
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk (clk_raw),
      .rst (rst),
      .raw (keystroke[g]),
      .deb (deb[g])
    );
  end

  always_ff @(posedge clk_raw) begin
    if (rst) begin
      commit_q <= 1'b0;
      mode_q   <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      commit_q <= deb[KS_COMMIT];
      mode_q   <= deb[KS_MODE];
      clear_q  <= deb[KS_CLEAR];
    end
  end

  assign commit_rise = deb[KS_COMMIT] & ~commit_q;
  assign clear_rise  = deb[KS_CLEAR] & ~clear_q;
  assign mode_chg    = deb[KS_MODE] ^ mode_q;
  assign pause_lvl   = deb[KS_PAUSE];

  cmd_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          pend_valid;
  logic [7:0]    pend_data;
  logic          overflow_q;
  state_t        state, state_nxt;

  logic          push_req, push_ok, pend_set, pend_clr, pend_drop;
  cmd_t          push_cmd;
  logic          full, valid_int, pop;

  // One push per cycle: MODE first, then a held LOAD, then a fresh LOAD.
  always_comb begin
    push_req  = 1'b0;
    push_cmd  = '0;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    pend_drop = 1'b0;
    if (mode_chg) begin
      push_req = 1'b1;
      push_cmd = '{op: OP_MODE, data: {7'b0, deb[KS_MODE]}};
      if (commit_rise) begin
        if (pend_valid) pend_drop = 1'b1;
        else            pend_set  = 1'b1;
      end
    end else if (pend_valid) begin
      push_req = 1'b1;
      push_cmd = '{op: OP_LOAD, data: pend_data};
      pend_clr = 1'b1;
      if (commit_rise) pend_set = 1'b1;
    end else if (commit_rise) begin
      push_req = 1'b1;
      push_cmd = '{op: OP_LOAD, data: deb[7:0]};
    end
  end

  assign full      = (count == CW'(FIFO_DEPTH));
  assign valid_int = ((state == S_RUN) && (count != '0)) || (state == S_CLEARING);
  assign cmd_valid = valid_int & ~rst;
  assign pop       = cmd_valid & cmd_ready;
  assign push_ok   = push_req & (~full | pop);
  assign count_nxt = count + CW'(push_ok) - CW'(pop);

  always_ff @(posedge clk_raw) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (clear_rise) begin
      // Flush everything and leave CLEAR as the only entry.
      mem[0]     <= '{op: OP_CLEAR, data: 8'h00};
      rd_ptr     <= '0;
      wr_ptr     <= AW'(1);
      count      <= CW'(1);
      pend_valid <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_cmd;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      if (pend_set) begin
        pend_valid <= 1'b1;
        pend_data  <= deb[7:0];
      end else if (pend_clr) begin
        pend_valid <= 1'b0;
      end
      if (pend_drop || (push_req && !push_ok)) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_raw) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (pause_lvl)          state_nxt = S_PAUSE;
        else if (count != '0)   state_nxt = S_RUN;
      end
      S_RUN: begin
        if (pause_lvl)             state_nxt = S_PAUSE;
        else if (count_nxt == '0)  state_nxt = S_IDLE;
      end
      S_PAUSE: begin
        if (!pause_lvl) state_nxt = (count_nxt != '0) ? S_RUN : S_IDLE;
      end
      S_CLEARING: begin
        if (pop) begin
          if (pause_lvl)              state_nxt = S_PAUSE;
          else if (count_nxt != '0)   state_nxt = S_RUN;
          else                        state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (clear_rise) state_nxt = S_CLEARING;
  end

  assign cmd_op     = cmd_valid ? mem[rd_ptr].op   : OP_NOP;
  assign cmd_data   = cmd_valid ? mem[rd_ptr].data : 8'h00;
  assign mode       = deb[KS_MODE];
  assign paused     = (state == S_PAUSE);
  assign overflow   = overflow_q;
  assign fifo_count = count;

endmodule

// File: tb/tb_keystroke_sequencer.sv
// Bench for keystroke_sequencer: event table, hand-written corner sequences
// and random keystroke traffic against a command-stream model.
module tb_keystroke_sequencer;

  localparam logic [1:0] L_LOAD  = 2'd1;
  localparam logic [1:0] L_MODE  = 2'd2;
  localparam logic [1:0] L_CLEAR = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] ks;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        mode, paused, overflow;
  logic [2:0]  fifo_count;

  int checks = 0;
  int failures = 0;
  int valid_seen = 0;
  logic [9:0] exp_q[$];

  keystroke_sequencer #(.DEB_CYCLES(2), .FIFO_DEPTH(4)) dut (
    .clk_raw    (clk),
    .rst        (rst),
    .keystroke  (ks),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .mode       (mode),
    .paused     (paused),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: every accepted command must match the head of exp_q
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL issued_cmd actual=%h required=none", {cmd_op, cmd_data});
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({cmd_op, cmd_data} !== e) begin
          failures++;
          $display("FAIL issued_cmd actual=%h required=%h", {cmd_op, cmd_data}, e);
        end
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (cmd_valid) valid_seen++;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic hold_rand(input int n);
    repeat (n) begin
      cmd_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pulse_commit(input logic [7:0] v);
    ks[7:0] = v;
    ks[8] = 1'b1;
    tick_n(5);
    ks[8] = 1'b0;
    tick_n(5);
  endtask

  typedef struct {
    logic [7:0] val;
    logic       commit;
    logic       mode_lvl;
    logic       clr;
    int         n_exp;
    logic [9:0] e0;
    logic [9:0] e1;
  } vec_t;

  vec_t vecs[8];
  int   n;
  logic model_mode;

  initial begin
    vecs[0] = '{8'h11, 1'b1, 1'b0, 1'b0, 1, {L_LOAD, 8'h11}, 10'h0};
    vecs[1] = '{8'h22, 1'b0, 1'b1, 1'b0, 1, {L_MODE, 8'h01}, 10'h0};
    vecs[2] = '{8'h33, 1'b1, 1'b1, 1'b0, 1, {L_LOAD, 8'h33}, 10'h0};
    vecs[3] = '{8'h44, 1'b1, 1'b0, 1'b0, 2, {L_MODE, 8'h00}, {L_LOAD, 8'h44}};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 1, {L_CLEAR, 8'h00}, 10'h0};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b0, 2, {L_MODE, 8'h01}, {L_LOAD, 8'hFF}};
    vecs[6] = '{8'h55, 1'b1, 1'b1, 1'b1, 1, {L_CLEAR, 8'h00}, 10'h0};
    vecs[7] = '{8'h66, 1'b0, 1'b0, 1'b1, 1, {L_CLEAR, 8'h00}, 10'h0};

    rst = 1'b1;
    ks = '0;
    cmd_ready = 1'b0;
    tick_n(3);
    rst = 1'b0;
    tick();
    chk("rst_valid", cmd_valid, 0);
    chk("rst_op", cmd_op, 0);
    chk("rst_data", cmd_data, 0);
    chk("rst_mode", mode, 0);
    chk("rst_paused", paused, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_count", fifo_count, 0);

    // event table
    cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].n_exp > 0) exp_q.push_back(vecs[i].e0);
      if (vecs[i].n_exp > 1) exp_q.push_back(vecs[i].e1);
      ks[7:0] = vecs[i].val;
      ks[8]   = vecs[i].commit;
      ks[9]   = vecs[i].mode_lvl;
      ks[10]  = vecs[i].clr;
      tick_n(10);
      ks[8]  = 1'b0;
      ks[10] = 1'b0;
      tick_n(10);
      chk("vec_drained", exp_q.size(), 0);
      chk("vec_mode", mode, vecs[i].mode_lvl);
      chk("vec_count", fifo_count, 0);
    end

    // latency of a 2-cycle commit pulse
    ks[7:0] = 8'h82;
    exp_q.push_back({L_LOAD, 8'h82});
    ks[8] = 1'b1;
    n = 0;
    while (!cmd_valid && n < 20) begin
      tick();
      n++;
      if (n == 2) ks[8] = 1'b0;
    end
    checks++;
    if (!(n >= 5 && n <= 6)) begin
      failures++;
      $display("FAIL commit_latency actual=%0d required=5..6", n);
    end
    tick_n(10);
    chk("latency_drained", exp_q.size(), 0);
    chk("latency_count", fifo_count, 0);

    // overflow with the core stalled
    cmd_ready = 1'b0;
    for (int k = 1; k <= 6; k++) pulse_commit(8'(k));
    tick_n(6);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_valid_held", cmd_valid, 1);
    chk("ovf_head", {cmd_op, cmd_data}, {L_LOAD, 8'h01});
    for (int k = 1; k <= 4; k++) exp_q.push_back({L_LOAD, 8'(k)});
    cmd_ready = 1'b1;
    tick_n(10);
    chk("ovf_drained", exp_q.size(), 0);
    chk("ovf_empty", fifo_count, 0);
    chk("ovf_idle_valid", cmd_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // pause holds off issue
    ks[11] = 1'b1;
    tick_n(8);
    chk("pause_paused", paused, 1);
    valid_seen = 0;
    pulse_commit(8'hA1);
    pulse_commit(8'hA2);
    tick_n(6);
    chk("pause_no_valid", valid_seen, 0);
    chk("pause_count", fifo_count, 2);
    exp_q.push_back({L_LOAD, 8'hA1});
    exp_q.push_back({L_LOAD, 8'hA2});
    ks[11] = 1'b0;
    tick_n(12);
    chk("pause_drained", exp_q.size(), 0);
    chk("pause_released", paused, 0);

    // clear while paused with overflow still set
    ks[11] = 1'b1;
    tick_n(8);
    valid_seen = 0;
    pulse_commit(8'hB1);
    pulse_commit(8'hB2);
    pulse_commit(8'hB3);
    tick_n(6);
    chk("clr_pre_count", fifo_count, 3);
    chk("clr_pre_ovf", overflow, 1);
    chk("clr_pre_no_valid", valid_seen, 0);
    exp_q.push_back({L_CLEAR, 8'h00});
    ks[10] = 1'b1;
    tick_n(5);
    ks[10] = 1'b0;
    tick_n(10);
    chk("clr_issued", exp_q.size(), 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_paused", paused, 1);
    chk("clr_count", fifo_count, 0);
    chk("clr_valid", cmd_valid, 0);
    ks[11] = 1'b0;
    tick_n(8);
    chk("clr_unpaused", paused, 0);

    // reset mid-transfer
    cmd_ready = 1'b0;
    ks[7:0] = 8'h33;
    ks[8] = 1'b1;
    tick_n(5);
    ks[8] = 1'b0;
    n = 0;
    while (!cmd_valid && n < 20) begin
      tick();
      n++;
    end
    chk("rstmid_valid_before", cmd_valid, 1);
    rst = 1'b1;
    tick();
    chk("rstmid_valid", cmd_valid, 0);
    chk("rstmid_op", cmd_op, 0);
    chk("rstmid_data", cmd_data, 0);
    chk("rstmid_count", fifo_count, 0);
    chk("rstmid_overflow", overflow, 0);
    chk("rstmid_paused", paused, 0);
    rst = 1'b0;
    tick_n(8);
    chk("rstmid_stays_empty", fifo_count, 0);

    // single-cycle glitch is filtered
    cmd_ready = 1'b1;
    valid_seen = 0;
    ks[8] = 1'b1;
    tick();
    ks[8] = 1'b0;
    tick_n(12);
    chk("glitch_no_valid", valid_seen, 0);
    chk("glitch_count", fifo_count, 0);

    // random traffic against the command-stream model
    model_mode = 1'b0;
    ks = '0;
    tick_n(10);
    for (int it = 0; it < 40; it++) begin
      int op;
      logic [7:0] v;
      op = $urandom_range(0, 9);
      v = 8'($urandom);
      if (op >= 9) begin
        cmd_ready = 1'b1;
        tick_n(10);
        exp_q.delete();
        exp_q.push_back({L_CLEAR, 8'h00});
        ks[10] = 1'b1;
      end else begin
        ks[7:0] = v;
        if (op >= 3 && op <= 5) begin
          model_mode = ~model_mode;
          exp_q.push_back({L_MODE, 7'b0, model_mode});
          ks[9] = model_mode;
        end
        if (op <= 2 || op >= 6) begin
          if (op >= 6) begin
            model_mode = ~model_mode;
            exp_q.push_back({L_MODE, 7'b0, model_mode});
            ks[9] = model_mode;
          end
          exp_q.push_back({L_LOAD, v});
          ks[8] = 1'b1;
        end
      end
      hold_rand(8);
      ks[8]  = 1'b0;
      ks[10] = 1'b0;
      hold_rand(8);
    end
    cmd_ready = 1'b1;
    tick_n(12);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_mode", mode, model_mode);
    chk("rand_overflow", overflow, 0);
    chk("rand_count", fifo_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
